// File: rtl/store_write_queue_pkg.sv
// Shared widths and store-length constants for the store write queue.
// Imported by the queue top level and its byte serializer.
package store_write_queue_pkg;

  localparam int BYTE_W         = 8;
  localparam int MEM_W          = BYTE_W;
  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_BYTES_DEF = 4;
  localparam int BUS_W_DEF      = BYTE_W * DATA_BYTES_DEF;

  localparam int LEN_B = 1;
  localparam int LEN_H = 2;
  localparam int LEN_W = 4;

endpackage

// File: rtl/store_byte_serializer.sv
// Walks the head store one byte per accepted RAM cycle.
// Ports: clk/rst, rdy, head entry (valid/addr/data/len), ram handshake in,
// ram_write/ram_addr/ram_data out, retire pulse when the last byte lands.
module store_byte_serializer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int LEN_W      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     head_valid,
  input  logic [ADDR_W-1:0]        head_addr,
  input  logic [8*DATA_BYTES-1:0]  head_data,
  input  logic [LEN_W-1:0]         head_len,
  input  logic                     ram_busy,
  input  logic                     io_buffer_full,
  input  logic                     ram_success,
  output logic                     ram_write,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [store_write_queue_pkg::MEM_W-1:0] ram_data,
  output logic                     retire
);
  import store_write_queue_pkg::*;

  logic [LEN_W-1:0] cur;
  logic             fire;
  logic             last;

  assign ram_write = rdy && head_valid
                  && !ram_busy && !io_buffer_full;
  assign fire      = ram_write && ram_success;

  // >= instead of == keeps a malformed length from
  // ever wedging the cursor past the end.
  assign last   = ({1'b0, cur} + (LEN_W+1)'(1))
               >= {1'b0, head_len};
  assign retire = fire && last;

  assign ram_addr = head_addr + ADDR_W'(cur);

  always_comb begin
    ram_data = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (cur == LEN_W'(i))
        ram_data = head_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
    end else if (fire) begin
      cur <= last ? '0 : cur + LEN_W'(1);
    end
  end

endmodule

// File: rtl/store_write_queue.sv
// DEPTH-entry store FIFO drained byte-serially to a byte-wide RAM port,
// with a combinational load/store overlap check. Ports: clk/rst, rdy,
// push_*, full/empty/count, chk_addr/chk_len/chk_hit, ram_* handshake.
module store_write_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int LEN_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          push,
  input  logic [LEN_W-1:0]              push_len,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [8*DATA_BYTES-1:0]       push_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  input  logic [ADDR_W-1:0]             chk_addr,
  input  logic [LEN_W-1:0]              chk_len,
  output logic                          chk_hit,
  input  logic                          io_buffer_full,
  input  logic                          ram_busy,
  input  logic                          ram_success,
  output logic                          ram_write,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [7:0]                    ram_data
);
  import store_write_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DW    = BYTE_W * DATA_BYTES;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DW-1:0]     data_q [DEPTH];
  logic [LEN_W-1:0]  len_q  [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt_q;

  logic              len_ok;
  logic              push_ok;
  logic              retire;
  logic [DEPTH-1:0]  hit_vec;
  logic [ADDR_W:0]   c_end;

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  assign len_ok  = (push_len != '0)
                && (push_len <= LEN_W'(DATA_BYTES));
  // full comes from the registered count, so a
  // same-cycle retire never makes room for a push.
  assign push_ok = rdy && push && !full && len_ok;

  store_byte_serializer #(
    .ADDR_W     (ADDR_W),
    .DATA_BYTES (DATA_BYTES),
    .LEN_W      (LEN_W)
  ) u_ser (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .head_valid     (!empty),
    .head_addr      (addr_q[head]),
    .head_data      (data_q[head]),
    .head_len       (len_q[head]),
    .ram_busy       (ram_busy),
    .io_buffer_full (io_buffer_full),
    .ram_success    (ram_success),
    .ram_write      (ram_write),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .retire         (retire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (push_ok) begin
        addr_q[tail] <= push_addr;
        data_q[tail] <= push_data;
        len_q[tail]  <= push_len;
        vld_q[tail]  <= 1'b1;
        tail         <= tail + PTR_W'(1);
      end
      // tail != head whenever both fire, since push
      // needs !full and retire needs !empty.
      if (retire) begin
        vld_q[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      unique case ({push_ok, retire})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Ends are formed one bit wider so ranges near
  // the top of memory do not wrap to zero.
  assign c_end = {1'b0, chk_addr} + (ADDR_W+1)'(chk_len);

  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    logic [ADDR_W:0] e_end;
    assign e_end = {1'b0, addr_q[i]}
                 + (ADDR_W+1)'(len_q[i]);
    assign hit_vec[i] = vld_q[i]
                     && ({1'b0, addr_q[i]} < c_end)
                     && ({1'b0, chk_addr} < e_end);
  end

  assign chk_hit = (chk_len != '0) && (|hit_vec);

endmodule

// File: tb/tb_store_write_queue.sv
// Directed self-checking bench for store_write_queue.
// Inputs change 1ns after posedge; outputs checked before the next edge.
module tb_store_write_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, push;
  logic [2:0]  push_len;
  logic [31:0] push_addr, push_data;
  logic        full, empty;
  logic [2:0]  count;
  logic [31:0] chk_addr;
  logic [2:0]  chk_len;
  logic        chk_hit;
  logic        io_buffer_full, ram_busy, ram_success;
  logic        ram_write;
  logic [31:0] ram_addr;
  logic [7:0]  ram_data;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  store_write_queue dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .push           (push),
    .push_len       (push_len),
    .push_addr      (push_addr),
    .push_data      (push_data),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .chk_addr       (chk_addr),
    .chk_len        (chk_len),
    .chk_hit        (chk_hit),
    .io_buffer_full (io_buffer_full),
    .ram_busy       (ram_busy),
    .ram_success    (ram_success),
    .ram_write      (ram_write),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_push(input logic [2:0] l,
                          input logic [31:0] a,
                          input logic [31:0] d);
    push = 1'b1; push_len = l; push_addr = a; push_data = d;
  endtask

  task automatic check_byte(input string tag,
                            input logic [31:0] a,
                            input logic [7:0] d);
    check({tag, "_wr"}, 64'(ram_write), 64'd1);
    check({tag, "_addr"}, 64'(ram_addr), 64'(a));
    check({tag, "_data"}, 64'(ram_data), 64'(d));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; push = 1'b0;
    push_len = '0; push_addr = '0; push_data = '0;
    chk_addr = '0; chk_len = 3'd4;
    io_buffer_full = 1'b0; ram_busy = 1'b0; ram_success = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wr",    64'(ram_write), 64'd0);
    check("rst_hit",   64'(chk_hit), 64'd0);

    // invalid lengths are ignored
    set_push(3'd0, 32'h50, 32'h1); tick();
    set_push(3'd5, 32'h50, 32'h1); tick();
    push = 1'b0; #1;
    check("badlen_empty", 64'(empty), 64'd1);

    // basic word store
    ram_success = 1'b1;
    set_push(3'd4, 32'h100, 32'hAABBCCDD); tick();
    push = 1'b0; #1;
    check("w_count", 64'(count), 64'd1);
    check_byte("w0", 32'h100, 8'hDD); tick();
    check_byte("w1", 32'h101, 8'hCC); tick();
    check_byte("w2", 32'h102, 8'hBB); tick();
    check_byte("w3", 32'h103, 8'hAA); tick();
    check("w_empty", 64'(empty), 64'd1);
    check("w_nowr", 64'(ram_write), 64'd0);

    // fill while busy, 5th dropped
    ram_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_push(3'd1, 32'h300 + k, 32'h11 + k);
      tick();
      if (k == 3) begin
        check("fill_count4", 64'(count), 64'd4);
        check("fill_full",   64'(full),  64'd1);
      end
    end
    push = 1'b0; #1;
    check("fill_count5", 64'(count), 64'd4);
    check("busy_nowr", 64'(ram_write), 64'd0);
    ram_busy = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      check_byte($sformatf("fifo%0d", k), 32'h300 + k, 8'(8'h11 + k));
      tick();
    end
    check("fifo_empty", 64'(empty), 64'd1);

    // io_buffer_full and failed attempts mid-word
    set_push(3'd4, 32'h400, 32'h44332211); tick();
    push = 1'b0; #1;
    check_byte("m0", 32'h400, 8'h11); tick();
    check_byte("m1", 32'h401, 8'h22); tick();
    io_buffer_full = 1'b1; #1;
    check("iobf_nowr", 64'(ram_write), 64'd0);
    tick(); tick();
    check("iobf_nowr2", 64'(ram_write), 64'd0);
    io_buffer_full = 1'b0; ram_success = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      check_byte($sformatf("retry%0d", k), 32'h402, 8'h33);
      tick();
    end
    check_byte("m2", 32'h402, 8'h33);
    ram_success = 1'b1; tick();
    check_byte("m3", 32'h403, 8'h44); tick();
    check("m_empty", 64'(empty), 64'd1);

    // overlap check
    ram_busy = 1'b1;
    set_push(3'd2, 32'h202, 32'h0000BEEF); tick();
    push = 1'b0;
    chk_addr = 32'h200; chk_len = 3'd4; #1;
    check("hit_200_4", 64'(chk_hit), 64'd1);
    chk_addr = 32'h203; chk_len = 3'd1; #1;
    check("hit_203_1", 64'(chk_hit), 64'd1);
    chk_addr = 32'h204; chk_len = 3'd1; #1;
    check("hit_204_1", 64'(chk_hit), 64'd0);
    chk_addr = 32'h1FF; chk_len = 3'd1; #1;
    check("hit_1ff_1", 64'(chk_hit), 64'd0);
    chk_addr = 32'h202; chk_len = 3'd0; #1;
    check("hit_len0", 64'(chk_hit), 64'd0);
    ram_busy = 1'b0; tick(); tick();
    chk_addr = 32'h200; chk_len = 3'd4; #1;
    check("hit_retired", 64'(chk_hit), 64'd0);
    check("hit_empty", 64'(empty), 64'd1);

    // push and retire in the same cycle
    set_push(3'd2, 32'h500, 32'h0000BBAA); tick();
    push = 1'b0; #1;
    check_byte("pr0", 32'h500, 8'hAA); tick();
    check_byte("pr1", 32'h501, 8'hBB);
    set_push(3'd1, 32'h600, 32'h66); tick();
    push = 1'b0; #1;
    check("pr_count", 64'(count), 64'd1);
    check_byte("pr_next", 32'h600, 8'h66); tick();
    check("pr_empty", 64'(empty), 64'd1);

    // push while full with retire: dropped
    ram_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_push(3'd1, 32'h700 + k, 32'h71 + k);
      tick();
    end
    ram_busy = 1'b0;
    set_push(3'd1, 32'h7FF, 32'h7F); #1;
    check("fr_full", 64'(full), 64'd1);
    check_byte("fr0", 32'h700, 8'h71); tick();
    push = 1'b0; #1;
    check("fr_count", 64'(count), 64'd3);
    check_byte("fr1", 32'h701, 8'h72); tick();
    check_byte("fr2", 32'h702, 8'h73); tick();
    check_byte("fr3", 32'h703, 8'h74); tick();
    check("fr_empty", 64'(empty), 64'd1);

    // reset mid-entry
    set_push(3'd4, 32'h800, 32'h88776655); tick();
    push = 1'b0; tick(); tick();
    check_byte("rm2", 32'h802, 8'h77);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    check("rm_empty", 64'(empty), 64'd1);
    check("rm_nowr",  64'(ram_write), 64'd0);
    check("rm_count", 64'(count), 64'd0);

    // rdy freeze mid-entry
    set_push(3'd4, 32'h900, 32'h99887766); tick();
    push = 1'b0; tick();
    check_byte("rd1", 32'h901, 8'h77);
    rdy = 1'b0;
    set_push(3'd1, 32'hA00, 32'h1); #1;
    check("rd_nowr", 64'(ram_write), 64'd0);
    tick(); tick();
    push = 1'b0; #1;
    check("rd_count", 64'(count), 64'd1);
    rdy = 1'b1; #1;
    check_byte("rd1b", 32'h901, 8'h77); tick();
    check_byte("rd2", 32'h902, 8'h88); tick();
    check_byte("rd3", 32'h903, 8'h99); tick();
    check("rd_empty", 64'(empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
